segasys1_sndcmd_mbox: RTL
=========================

// Module: segasys1_sndcmd_mbox
// PURPOSE
//  Parametrised main-to-sound command mailbox. It replaces the single-entry sound-request latch.
//  - Main Z80 OUT writes to either command port are queued in a FIFO.
//  - The sound side pops entries with an acknowledge; the request line is driven in pulse or level mode.
//  - A status port gives fill state and a sticky overflow flag. Its read data feeds the main CPU data selector.
// PARAMETERS
//  DW        8      command width (bits)
//  AW        2      FIFO depth = 2**AW entries (AW >= 1)
//  PORT_A    8'h14  first command port (CPUAD[7:0])
//  PORT_B    8'h18  mirror command port
//  PORT_ST   8'h1A  status port (read: status; write: clear OVF)
//  REQ_LVL   0      0 = SNDRQ pulses per entry; 1 = SNDRQ = FIFO non-empty
//  PULSE_LEN 4      SNDRQ pulse width in CLK48M cycles (>= 1; pulse mode only)
// PORTS
//  CLK48M  in   1       system clock; all state on rising edge
//  RESET   in   1       asynchronous, active-high reset
//  CPUAD   in   16      main CPU address; only [7:0] decoded
//  CPUIO   in   1       main CPU IORQ (active high)
//  CPUWR   in   1       main CPU write strobe (active high, held several clocks)
//  CPURD   in   1       main CPU read strobe (active high, held several clocks)
//  CPUDO   in   DW      main CPU write data
//  STCS    out  1       status port selected for read (CPUIO & CPURD & addr==PORT_ST)
//  STDO    out  8       status byte {OVF, FULL, EMPTY, 0.., COUNT}; COUNT occupies [AW:0]
//  SNDRQ   out  1       request to sound CPU
//  SNDNO   out  DW      head-of-FIFO command; 0 when empty
//  SNDACK  in   1       sound side pop strobe (level; rising edge consumed)
// BEHAVIOUR
//  Reset: FIFO empty, COUNT=0, OVF=0, SNDRQ=0, SNDNO=0, pulse counter 0, edge registers 0.
//    Reset is asynchronous, mid-operation included; all queued entries are discarded.
//  Strobe edge detection:
//    - wr_cmd = CPUIO & CPUWR & (addr==PORT_A | addr==PORT_B); its rising edge is a push request.
//    - wr_st = write to PORT_ST; its rising edge clears OVF.
//    - rd_st = STCS; its rising edge clears OVF one cycle after the edge, so the read in progress still sees OVF=1.
//    - SNDACK rising edge is a pop request.
//    - A held strobe acts exactly once.
//  Push: when not full, mem[wp] <= CPUDO at the edge cycle; wp++; COUNT++.
//    When full, the data is dropped, OVF <= 1 (sticky), and nothing else changes.
//  Pop: when not empty, rp++; COUNT--. When empty, the pop is ignored with no error.
//  Simultaneous push+pop:
//    - Not full and not empty: both act; COUNT is unchanged.
//    - Empty: push only.
//    - Full: both act, the push is accepted, and OVF is not set.
//    - OVF set by a push and cleared by a clear edge in the same cycle: the set wins.
//  Pointers are AW bits and wrap modulo 2**AW. COUNT is AW+1 bits (0..2**AW).
//    FULL = COUNT==2**AW; EMPTY = COUNT==0.
//  SNDNO = mem[rp] when non-empty, else 0. It is valid the cycle after a push into an empty FIFO.
//  SNDRQ, level mode: SNDRQ is the registered ~EMPTY, asserted 1 cycle after the push edge.
//  SNDRQ, pulse mode: a 2-state FSM, IDLE / PULSE.
//    - IDLE -> PULSE when the FIFO is non-empty and the previous pulse was acknowledged (armed).
//    - PULSE holds SNDRQ=1 for exactly PULSE_LEN cycles, then returns to IDLE and disarms.
//    - A pop edge re-arms the FSM, so one pulse is issued per entry.
//    - After reset the FSM is armed.
//  STDO is combinational from registered state and is valid whenever STCS=1. STCS is decode only.
//  Latency: push edge -> COUNT/SNDNO visible 1 cycle; -> SNDRQ (either mode) 1 cycle.
// TESTING
//  1. Reset; OUT 0x14 <- 0x5A, CPUWR held 8 cycles -> COUNT=1 (not 8), SNDNO=0x5A,
//     SNDRQ pulse exactly 4 cycles starting 1 cycle after the edge.
//  2. AW=2: five writes 0x01..0x05 with no ACK -> FULL=1, OVF=1, STDO=8'hC4, 0x05 dropped.
//     Four ACKs -> SNDNO 01,02,03,04, then 0; EMPTY=1; one pulse per entry.
//  3. FIFO full; push 0x77 and ACK edge in the same cycle -> COUNT stays 4, OVF stays 0,
//     0x77 is popped last; repeat with wr/rd pointers wrapped past 3.
//  4. OVF=1; IN from 0x1A -> that read returns bit7=1, the next read returns bit7=0.
//     OUT to 0x1A also clears OVF.
//  5. REQ_LVL=1: push 0x33 -> SNDRQ high next cycle and stays high until the ACK empties the FIFO.
//     ACK while empty -> no change.
//  6. Assert RESET asynchronously mid-pulse with COUNT=3 -> SNDRQ, SNDNO, COUNT and OVF go to 0 with no clock edge.

Source files
------------

// File: rtl/segasys1_sndcmd_mbox.sv
// segasys1_sndcmd_mbox
//   Main-to-sound command mailbox. Main CPU OUT writes to either command
//   port are queued in a small FIFO. The sound side pops the head entry with
//   an acknowledge strobe. The sound request line runs in one of two modes:
//   one fixed-length pulse per entry, or a level that is high while the FIFO
//   holds data. A status port reports the fill state and a sticky overflow
//   flag.
//
// Ports
//   CLK48M  in   1   system clock, all state on the rising edge
//   RESET   in   1   asynchronous, active-high reset
//   CPUAD   in   16  main CPU address, only [7:0] decoded
//   CPUIO   in   1   main CPU IORQ (active high)
//   CPUWR   in   1   main CPU write strobe (active high)
//   CPURD   in   1   main CPU read strobe (active high)
//   CPUDO   in   DW  main CPU write data
//   STCS    out  1   status port selected for read (decode only)
//   STDO    out  8   status {OVF, FULL, EMPTY, 0.., COUNT[AW:0]}, needs AW <= 4
//   SNDRQ   out  1   request to the sound CPU
//   SNDNO   out  DW  head-of-FIFO command, 0 when empty
//   SNDACK  in   1   sound side pop strobe (level)
//
// Strobe semantics: CPU strobes and SNDACK are levels. Each one is an
// event only on its rising edge. A push is taken when the command-write
// strobe rises. A pop is taken when SNDACK rises. A strobe that is held
// high acts once. No back-pressure is visible to either side. A push into a
// full FIFO sets OVF, and a pop from an empty FIFO is ignored.
module segasys1_sndcmd_mbox #(
    parameter int         DW        = 8,
    parameter int         AW        = 2,
    parameter logic [7:0] PORT_A    = 8'h14,
    parameter logic [7:0] PORT_B    = 8'h18,
    parameter logic [7:0] PORT_ST   = 8'h1A,
    parameter bit         REQ_LVL   = 1'b0,
    parameter int         PULSE_LEN = 4
) (
    input  logic          CLK48M,
    input  logic          RESET,
    input  logic [15:0]   CPUAD,
    input  logic          CPUIO,
    input  logic          CPUWR,
    input  logic          CPURD,
    input  logic [DW-1:0] CPUDO,
    output logic          STCS,
    output logic [7:0]    STDO,
    output logic          SNDRQ,
    output logic [DW-1:0] SNDNO,
    input  logic          SNDACK
);

    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam int          PW       = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

    typedef enum logic { S_IDLE, S_PULSE } rq_state_t;

    logic [7:0]    addr;
    logic          wr_cmd, wr_st, rd_st;
    logic          wr_cmd_q, wr_st_q, rd_st_q, ack_q, rd_clr_q;
    logic          push_req, pop_ok, push_ok, ovf_set, ovf_clr;
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   count, count_next;
    logic          ovf, empty, full;
    rq_state_t     state;
    logic          armed, armed_next;
    logic [PW-1:0] pcnt;
    logic          unused_ok;

    assign addr      = CPUAD[7:0];
    assign unused_ok = &{1'b0, CPUAD[15:8]};

    assign wr_cmd = CPUIO & CPUWR & ((addr == PORT_A) | (addr == PORT_B));
    assign wr_st  = CPUIO & CPUWR & (addr == PORT_ST);
    assign rd_st  = CPUIO & CPURD & (addr == PORT_ST);
    assign STCS   = rd_st;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    assign push_req = wr_cmd & ~wr_cmd_q;
    assign pop_ok   = SNDACK & ~ack_q & ~empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still fits.
    assign push_ok  = push_req & (~full | pop_ok);
    assign ovf_set  = push_req & ~push_ok;
    // A status read clears OVF one cycle late, so the read in progress still sees it.
    assign ovf_clr  = (wr_st & ~wr_st_q) | rd_clr_q;

    always_comb begin
        count_next = count;
        if (push_ok & ~pop_ok)
            count_next = count + 1'b1;
        else if (~push_ok & pop_ok)
            count_next = count - 1'b1;
    end

    assign armed_next = armed | pop_ok;

    always_ff @(posedge CLK48M or posedge RESET) begin
        if (RESET) begin
            wr_cmd_q <= 1'b0;
            wr_st_q  <= 1'b0;
            rd_st_q  <= 1'b0;
            ack_q    <= 1'b0;
            rd_clr_q <= 1'b0;
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            ovf      <= 1'b0;
        end else begin
            wr_cmd_q <= wr_cmd;
            wr_st_q  <= wr_st;
            rd_st_q  <= rd_st;
            ack_q    <= SNDACK;
            rd_clr_q <= rd_st & ~rd_st_q;
            if (push_ok) wp <= wp + 1'b1;
            if (pop_ok)  rp <= rp + 1'b1;
            count <= count_next;
            if (ovf_set)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

    // FIFO storage is not reset. The SNDNO mux hides stale contents while COUNT is 0.
    always_ff @(posedge CLK48M) begin
        if (push_ok) mem[wp] <= CPUDO;
    end

    assign SNDNO = empty ? '0 : mem[rp];

    always_comb begin
        STDO       = '0;
        STDO[AW:0] = count;
        STDO[5]    = empty;
        STDO[6]    = full;
        STDO[7]    = ovf;
    end

    // Request FSM. The next-cycle count is used, so SNDRQ rises one cycle after
    // the push edge. Entering PULSE uses up the arm. A pop at any time, including
    // one during a pulse, re-arms the FSM, which gives one pulse per entry.
    // In level mode the FSM stays in IDLE and SNDRQ follows the registered ~EMPTY.
    always_ff @(posedge CLK48M or posedge RESET) begin
        if (RESET) begin
            state <= S_IDLE;
            armed <= 1'b1;
            pcnt  <= '0;
            SNDRQ <= 1'b0;
        end else begin
            if (pop_ok) armed <= 1'b1;
            if (REQ_LVL) begin
                SNDRQ <= (count_next != '0);
            end else begin
                case (state)
                    S_IDLE: begin
                        if (armed_next && (count_next != '0)) begin
                            state <= S_PULSE;
                            pcnt  <= PW'(PULSE_LEN - 1);
                            armed <= 1'b0;
                            SNDRQ <= 1'b1;
                        end else begin
                            SNDRQ <= 1'b0;
                        end
                    end
                    S_PULSE: begin
                        if (pcnt == '0) begin
                            state <= S_IDLE;
                            SNDRQ <= 1'b0;
                        end else begin
                            pcnt  <= pcnt - 1'b1;
                            SNDRQ <= 1'b1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        SNDRQ <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
